// File: rtl/async_vec_pkg.sv
// Shared types and constants for the toggle-handshake vector crossing.
package async_vec_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  localparam int DEFAULT_SYNC_STAGES = 3;

  // The watchdog counter is never narrower than this.
  localparam int TO_CNT_MIN_W = 8;

  // Counter width wide enough to hold the watchdog limit.
  function automatic int to_cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < TO_CNT_MIN_W) ? TO_CNT_MIN_W : w;
  endfunction

endpackage

// File: rtl/async_vec_sync_chain.sv
// Single-bit multi-flop synchronizer with async reset to 0.
// Used for in_ack here; the receive end reuses it for out_req.
module async_vec_sync_chain #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;

  // Shift the asynchronous input through DEPTH flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/async_vec_crossing_source.sv
// Transmit end of a toggle-handshake crossing for a small level vector.
// A word is captured into a holding register, out_req is flipped, and the
// block stays busy until the synchronized in_ack matches out_req.
// Optional watchdog: define ASYNC_VEC_SRC_TIMEOUT_EN to build a counter that
// abandons a transfer after TIMEOUT_CYCLES and sets a sticky timeout_err.
//
// Handshake: a word is taken at a rising edge where enq_valid and enq_ready
// are both 1. enq_ready is registered and only high in IDLE; enq_bits is
// not looked at while enq_ready is 0.
module async_vec_crossing_source
  import async_vec_pkg::*;
#(
  parameter int               WIDTH          = 4,
  parameter int               SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter logic [WIDTH-1:0] RESET_VALUE    = {WIDTH{1'b1}},
  parameter int               TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic [WIDTH-1:0] out_data,
  output logic             out_req,
  input  logic             in_ack,
  output logic             busy,
  output logic             timeout_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             req_q, req_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             ack_s;
  logic             accept;
  logic             expire;

  async_vec_sync_chain #(
    .DEPTH(SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (in_ack),
    .q_o (ack_s)
  );

  // ready_q is only ever 1 in IDLE, so this is the IDLE handshake.
  assign accept = enq_valid && ready_q;

`ifdef ASYNC_VEC_SRC_TIMEOUT_EN
  localparam int              CntW    = to_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            terr_q, terr_d;

  // Expire on the edge that completes the TIMEOUT_CYCLES-th waiting cycle.
  assign expire = (state_q == WAIT_ACK) && (cnt_q == CntLast);

  // Watchdog next state: clear on acceptance, count while waiting.
  always_comb begin
    cnt_d  = cnt_q;
    terr_d = terr_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == WAIT_ACK) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (expire) begin
      terr_d = 1'b1;
    end
  end

  // Watchdog registers; timeout_err is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // FSM next state; data and req only move on acceptance, together.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (accept) begin
          data_d  = enq_bits;
          req_d   = ~req_q;
          state_d = WAIT_ACK;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      WAIT_ACK: begin
        if ((ack_s == req_q) || expire) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM and registered outputs; ready stays 0 until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= RESET_VALUE;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign out_data  = data_q;
  assign out_req   = req_q;
  assign enq_ready = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_async_vec_crossing_source.sv
// Directed bench for async_vec_crossing_source (WIDTH=4, SYNC_STAGES=3).
// Timeout scenario is exercised when ASYNC_VEC_SRC_TIMEOUT_EN is defined.
module tb_async_vec_crossing_source;

  logic       clk;
  logic       rst;
  logic       enq_valid;
  logic       enq_ready;
  logic [3:0] enq_bits;
  logic [3:0] out_data;
  logic       out_req;
  logic       in_ack;
  logic       busy;
  logic       timeout_err;

  int n_checks;
  int n_fail;

  async_vec_crossing_source #(
    .WIDTH          (4),
    .SYNC_STAGES    (3),
    .RESET_VALUE    (4'hF),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_bits    (enq_bits),
    .out_data    (out_data),
    .out_req     (out_req),
    .in_ack      (in_ack),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Clock and initial reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset both ends (far side ack returns to 0), then one edge to ready.
  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_ack    = 1'b0;
    enq_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // Offer one word for exactly one edge.
  task automatic send(input logic [3:0] w);
    enq_bits  = w;
    enq_valid = 1'b1;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    send(4'h2);
    @(negedge clk);
    #2 rst = 1'b1;
    in_ack = 1'b0;
    #1;
    n_checks++;
    if (out_data !== 4'hF || out_req !== 1'b0 || enq_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_immediate: data=%h req=%b ready=%b busy=%b, required data=f req=0 ready=0 busy=0",
               out_data, out_req, enq_ready, busy);
    end
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_timeout_err: got %b required 0", timeout_err);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if (enq_ready !== 1'b1 || busy !== 1'b0 || out_data !== 4'hF || out_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b busy=%b data=%h req=%b, required ready=1 busy=0 data=f req=0",
               enq_ready, busy, out_data, out_req);
    end
  endtask

  task automatic test_single_transfer();
    do_reset();
    send(4'hA);  // edge N
    n_checks++;
    if (out_data !== 4'hA || out_req !== 1'b1 || enq_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept: data=%h req=%b ready=%b busy=%b, required data=a req=1 ready=0 busy=1",
               out_data, out_req, enq_ready, busy);
    end
    for (int k = 1; k <= 8; k++) begin
      enq_valid = 1'b1;        // must be ignored while waiting
      enq_bits  = 4'h6;
      tick();                  // edge N+k
      if (k == 5) in_ack = 1'b1;
      n_checks++;
      if (enq_ready !== 1'b0 || out_data !== 4'hA || out_req !== 1'b1) begin
        n_fail++;
        $display("FAIL single_wait edge N+%0d: ready=%b data=%h req=%b, required ready=0 data=a req=1",
                 k, enq_ready, out_data, out_req);
      end
    end
    enq_valid = 1'b0;
    tick();                    // edge N+9
    n_checks++;
    if (enq_ready !== 1'b1 || busy !== 1'b0 || out_data !== 4'hA) begin
      n_fail++;
      $display("FAIL single_done: ready=%b busy=%b data=%h, required ready=1 busy=0 data=a",
               enq_ready, busy, out_data);
    end
  endtask

  task automatic test_back_to_back();
    int         acc;
    logic       will_acc;
    logic [3:0] hist;
    do_reset();
    acc       = 0;
    hist      = 4'b0000;
    enq_bits  = 4'h3;
    enq_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      will_acc = enq_valid && enq_ready;
      tick();
      if (will_acc) begin
        acc++;
        if (acc == 1) begin
          n_checks++;
          if (out_data !== 4'h3 || out_req !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: data=%h req=%b, required data=3 req=1", out_data, out_req);
          end
          enq_bits = 4'hC;
        end else begin
          n_checks++;
          if (out_data !== 4'hC || out_req !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: data=%h req=%b, required data=c req=0", out_data, out_req);
          end
          enq_valid = 1'b0;
        end
      end else if (acc == 1) begin
        n_checks++;
        if (out_data !== 4'h3 || out_req !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_hold cycle %0d: data=%h req=%b, required data=3 req=1", cyc, out_data, out_req);
        end
      end
      // Far-side model: ack follows out_req four cycles later.
      hist   = {hist[2:0], out_req};
      in_ack = hist[3];
    end
    enq_valid = 1'b0;
    n_checks++;
    if (acc !== 2) begin
      n_fail++;
      $display("FAIL b2b_count: acceptances=%0d required 2", acc);
    end
    n_checks++;
    if (enq_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: ready=%b busy=%b, required ready=1 busy=0", enq_ready, busy);
    end
  endtask

  task automatic test_spurious_ack();
    do_reset();
    in_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (enq_ready !== 1'b1 || busy !== 1'b0 || out_req !== 1'b0 || out_data !== 4'hF) begin
        n_fail++;
        $display("FAIL spurious_ack cycle %0d: ready=%b busy=%b req=%b data=%h, required ready=1 busy=0 req=0 data=f",
                 k, enq_ready, busy, out_req, out_data);
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    int wait_cyc;
    do_reset();
    send(4'h7);
    tick();
    tick();
    @(negedge clk);
    #3 rst = 1'b1;
    in_ack = 1'b0;
    #1;
    n_checks++;
    if (out_req !== 1'b0 || out_data !== 4'hF || enq_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_abort: req=%b data=%h ready=%b busy=%b, required req=0 data=f ready=0 busy=0",
               out_req, out_data, enq_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if (enq_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: ready=%b busy=%b, required ready=1 busy=0", enq_ready, busy);
    end
    send(4'h5);                // edge M
    n_checks++;
    if (out_data !== 4'h5 || out_req !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_next_accept: data=%h req=%b busy=%b, required data=5 req=1 busy=1",
               out_data, out_req, busy);
    end
    in_ack   = 1'b1;
    wait_cyc = 0;
    while (enq_ready !== 1'b1 && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    n_checks++;
    if (wait_cyc !== 4) begin
      n_fail++;
      $display("FAIL midreset_ack_latency: cycles=%0d required 4", wait_cyc);
    end
  endtask

  task automatic test_timeout();
    int wait_cyc;
    do_reset();
    send(4'h1);
    wait_cyc = 0;
    while (enq_ready !== 1'b1 && wait_cyc < 40) begin
      tick();
      wait_cyc++;
    end
`ifdef ASYNC_VEC_SRC_TIMEOUT_EN
    n_checks++;
    if (wait_cyc !== 16 || timeout_err !== 1'b1 || out_req !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_fire: cycles=%0d err=%b req=%b, required cycles=16 err=1 req=1",
               wait_cyc, timeout_err, out_req);
    end
    send(4'h9);
    for (int k = 0; k < 5; k++) tick();
    n_checks++;
    if (timeout_err !== 1'b1 || out_req !== 1'b0 || out_data !== 4'h9) begin
      n_fail++;
      $display("FAIL timeout_sticky: err=%b req=%b data=%h, required err=1 req=0 data=9",
               timeout_err, out_req, out_data);
    end
`else
    n_checks++;
    if (wait_cyc !== 40 || timeout_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL no_timeout_wait: cycles=%0d err=%b busy=%b, required cycles=40 err=0 busy=1",
               wait_cyc, timeout_err, busy);
    end
`endif
    do_reset();
    n_checks++;
    if (timeout_err !== 1'b0 || enq_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_cleared: err=%b ready=%b, required err=0 ready=1", timeout_err, enq_ready);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    enq_valid = 1'b0;
    enq_bits  = 4'h0;
    in_ack    = 1'b0;
    test_reset();
    test_single_transfer();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid_transfer();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
